nes_mem_arb: RTL and testbench

NES_MEM_ARB -- requirements
Module: nes_mem_arb

---
 rtl/nes_mem_arb.sv | 163 ++++++++++++++++
 tb/tb_nes_mem_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_mem_arb.sv
// rtl/nes_mem_arb.sv - three-way arbiter (PPU/CPU/loader) onto one shared memory port
module nes_mem_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ppu_req,
  input  logic        ppu_we,
  input  logic        ppu_allow,
  input  logic [21:0] ppu_addr,
  input  logic [7:0]  ppu_wdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_allow,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        ldr_req,
  input  logic [21:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ppu_ack,
  output logic        cpu_ack,
  output logic        ldr_ack,
  output logic [7:0]  rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_ACK} state_t;
  typedef enum logic [1:0] {G_NONE, G_PPU, G_CPU, G_LDR} grant_t;

  state_t        r_state;
  grant_t        r_grant;
  logic          r_read;
  logic [CW-1:0] r_starve;

  grant_t        w_win;
  logic          w_allow;
  logic          w_we;
  logic [21:0]   w_addr;
  logic [7:0]    w_wdata;

  // Pick this cycle's winner: a starved loader jumps the queue, else ppu > cpu > ldr
  always_comb begin
    w_win   = G_NONE;
    w_allow = 1'b0;
    w_we    = 1'b0;
    w_addr  = 22'd0;
    w_wdata = 8'd0;
    if (ldr_req && (r_starve >= LIMIT)) begin
      w_win = G_LDR;
    end else if (ppu_req) begin
      w_win = G_PPU;
    end else if (cpu_req) begin
      w_win = G_CPU;
    end else if (ldr_req) begin
      w_win = G_LDR;
    end
    case (w_win)
      G_PPU: begin
        w_allow = ppu_allow;
        w_we    = ppu_we;
        w_addr  = ppu_addr;
        w_wdata = ppu_wdata;
      end
      G_CPU: begin
        w_allow = cpu_allow;
        w_we    = cpu_we;
        w_addr  = cpu_addr;
        w_wdata = cpu_wdata;
      end
      G_LDR: begin
        w_allow = 1'b1;
        w_we    = 1'b1;
        w_addr  = ldr_addr;
        w_wdata = ldr_wdata;
      end
      default: begin
        w_allow = 1'b0;
      end
    endcase
  end

  // Arbitration FSM, memory port registers, ack pulses and loader starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= G_NONE;
      r_read    <= 1'b0;
      r_starve  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 22'd0;
      mem_wdata <= 8'd0;
      ppu_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      rdata     <= 8'd0;
    end else begin
      ppu_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;

      // The counter only means something while the loader is actually waiting
      if (!ldr_req) begin
        r_starve <= '0;
      end else if (r_state == S_IDLE && w_win == G_LDR) begin
        r_starve <= '0;
      end else if (r_state == S_IDLE && (w_win == G_PPU || w_win == G_CPU) &&
                   r_starve != {CW{1'b1}}) begin
        r_starve <= r_starve + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_win != G_NONE) begin
            r_grant <= w_win;
            r_read  <= ~w_we;
            if (w_allow) begin
              mem_req   <= 1'b1;
              mem_we    <= w_we;
              mem_addr  <= w_addr;
              mem_wdata <= w_wdata;
              r_state   <= S_MEM;
            end else begin
              // Disallowed access: no memory cycle, reads return open bus
              rdata   <= 8'hFF;
              ppu_ack <= (w_win == G_PPU);
              cpu_ack <= (w_win == G_CPU);
              ldr_ack <= (w_win == G_LDR);
              r_state <= S_ACK;
            end
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (r_read) begin
              rdata <= mem_rdata;
            end
            ppu_ack <= (r_grant == G_PPU);
            cpu_ack <= (r_grant == G_CPU);
            ldr_ack <= (r_grant == G_LDR);
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_mem_arb.sv
// tb/tb_nes_mem_arb.sv - directed self-checking bench for nes_mem_arb
module tb_nes_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_req, ppu_we, ppu_allow;
  logic [21:0] ppu_addr;
  logic [7:0]  ppu_wdata;
  logic        cpu_req, cpu_we, cpu_allow;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        ldr_req;
  logic [21:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ppu_ack, cpu_ack, ldr_ack;
  logic [7:0]  rdata;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;

  nes_mem_arb #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_allow(ppu_allow),
    .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_allow(cpu_allow),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ppu_ack(ppu_ack), .cpu_ack(cpu_ack), .ldr_ack(ldr_ack),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder settings
  bit         mem_auto = 1'b1;
  int         mem_lat = 1;
  bit         mem_derived = 1'b1;
  logic [7:0] mem_fix = 8'h00;
  int         manual_req = 0;
  int         manual_done = 0;
  int         rcnt = 0;

  // Memory model: ack mem_lat negedges after mem_req, or a stray pulse on demand
  initial forever begin
    @(negedge clk);
    if (manual_req != manual_done) begin
      manual_done = manual_req;
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
    end else if (mem_auto && mem_req && !mem_ack) begin
      rcnt++;
      if (rcnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_derived ? (mem_addr[7:0] ^ 8'hA5) : mem_fix;
        rcnt      = 0;
      end
    end else begin
      mem_ack = 1'b0;
      if (!mem_req) rcnt = 0;
    end
  end

  // Pulse counters
  int n_ppu = 0, n_cpu = 0, n_ldr = 0, n_memreq = 0;
  initial forever begin
    @(negedge clk);
    if (ppu_ack) n_ppu++;
    if (cpu_ack) n_cpu++;
    if (ldr_ack) n_ldr++;
    if (mem_req) n_memreq++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ack(input int which, input int max_cyc, output int cyc);
    logic hit;
    cyc = -1;
    for (int i = 1; i <= max_cyc && cyc < 0; i++) begin
      @(negedge clk);
      hit = (which == 0) ? ppu_ack : (which == 1) ? cpu_ack : ldr_ack;
      if (hit) cyc = i;
    end
  endtask

  task automatic wait_any(input int max_cyc, output int who);
    who = -1;
    for (int i = 1; i <= max_cyc && who < 0; i++) begin
      @(negedge clk);
      if (ppu_ack) who = 0;
      else if (cpu_ack) who = 1;
      else if (ldr_ack) who = 2;
    end
  endtask

  int cyc, who;
  int b_ppu, b_cpu, b_ldr, b_mr;
  int exp_seq [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0};

  initial begin
    reset = 1'b1;
    ppu_req = 0; ppu_we = 0; ppu_allow = 1; ppu_addr = '0; ppu_wdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_allow = 1; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_acks", {ppu_ack, cpu_ack, ldr_ack}, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // CPU read, memory answers 2 cycles after mem_req with 5A
    mem_derived = 0; mem_fix = 8'h5A; mem_lat = 2;
    cpu_req = 1; cpu_we = 0; cpu_allow = 1; cpu_addr = 22'h00_4123; cpu_wdata = 8'h77;
    @(negedge clk);
    check("cpu_rd_mem_req", mem_req, 1);
    check("cpu_rd_mem_addr", mem_addr, 22'h00_4123);
    check("cpu_rd_mem_we", mem_we, 0);
    cpu_addr = 22'h3A_BCDE;
    @(negedge clk);
    check("cpu_rd_req_stable", mem_req, 1);
    check("cpu_rd_addr_stable", mem_addr, 22'h00_4123);
    wait_ack(1, 10, cyc);
    check("cpu_rd_ack_lat", cyc, 1);
    check("cpu_rd_rdata", rdata, 8'h5A);
    check("cpu_rd_req_drop", mem_req, 0);
    cpu_req = 0;
    @(negedge clk);
    check("cpu_rd_ack_one", cpu_ack, 0);
    check("cpu_rd_rdata_hold", rdata, 8'h5A);

    // PPU and CPU together: ppu first, cpu right after
    @(negedge clk); #1;
    b_ppu = n_ppu; b_cpu = n_cpu;
    mem_derived = 1; mem_lat = 1;
    ppu_req = 1; ppu_we = 0; ppu_allow = 1; ppu_addr = 22'h00_1234;
    cpu_req = 1; cpu_we = 0; cpu_allow = 1; cpu_addr = 22'h00_00F0;
    wait_ack(0, 10, cyc);
    check("pri_ppu_lat", cyc, 2);
    check("pri_ppu_rdata", rdata, 8'h91);
    check("pri_cpu_waits", cpu_ack, 0);
    ppu_req = 0;
    wait_ack(1, 10, cyc);
    check("pri_cpu_lat", cyc, 3);
    check("pri_cpu_rdata", rdata, 8'h55);
    cpu_req = 0;
    repeat (2) @(negedge clk); #1;
    check("pri_ppu_pulses", n_ppu - b_ppu, 1);
    check("pri_cpu_pulses", n_cpu - b_cpu, 1);

    // Disallowed CPU write: no memory cycle, open-bus data
    b_mr = n_memreq;
    cpu_req = 1; cpu_we = 1; cpu_allow = 0; cpu_addr = 22'h00_8000; cpu_wdata = 8'h12;
    wait_ack(1, 10, cyc);
    check("dis_ack_lat", cyc, 1);
    check("dis_rdata", rdata, 8'hFF);
    check("dis_mem_req", mem_req, 0);
    cpu_req = 0; cpu_allow = 1; cpu_we = 0;
    repeat (2) @(negedge clk); #1;
    check("dis_no_mem_req", n_memreq - b_mr, 0);

    // Loader write at top address
    ldr_req = 1; ldr_addr = 22'h3F_FFFF; ldr_wdata = 8'hC3;
    @(negedge clk);
    check("ldr_mem_req", mem_req, 1);
    check("ldr_mem_we", mem_we, 1);
    check("ldr_mem_addr", mem_addr, 22'h3F_FFFF);
    check("ldr_mem_wdata", mem_wdata, 8'hC3);
    wait_ack(2, 10, cyc);
    check("ldr_ack_lat", cyc, 1);
    check("ldr_rdata_kept", rdata, 8'hFF);
    ldr_req = 0;
    repeat (2) @(negedge clk);

    // Starvation: ppu and cpu keep requesting, loader forced on 9th grant
    ppu_req = 1; ppu_we = 0; ppu_allow = 1; ppu_addr = 22'h00_0010;
    cpu_req = 1; cpu_we = 0; cpu_allow = 1; cpu_addr = 22'h00_0011;
    ldr_req = 1; ldr_addr = 22'h00_0020; ldr_wdata = 8'h5E;
    for (int g = 0; g < 10; g++) begin
      wait_any(20, who);
      check($sformatf("starve_grant%0d", g), who, exp_seq[g]);
    end
    ppu_req = 0; cpu_req = 0; ldr_req = 0;
    repeat (4) @(negedge clk); #1;

    // Spurious mem_ack in IDLE
    b_ppu = n_ppu; b_cpu = n_cpu; b_ldr = n_ldr;
    manual_req++;
    repeat (3) @(negedge clk); #1;
    check("spur_no_ack", (n_ppu - b_ppu) + (n_cpu - b_cpu) + (n_ldr - b_ldr), 0);
    check("spur_mem_req", mem_req, 0);
    @(negedge clk);
    ppu_req = 1; ppu_we = 0; ppu_allow = 1; ppu_addr = 22'h00_00C7;
    wait_ack(0, 10, cyc);
    check("spur_next_lat", cyc, 2);
    check("spur_next_rdata", rdata, 8'h62);
    ppu_req = 0;
    repeat (2) @(negedge clk);

    // Reset while in MEM, then a late mem_ack
    mem_auto = 0;
    cpu_req = 1; cpu_we = 0; cpu_allow = 1; cpu_addr = 22'h00_0ABC;
    @(negedge clk);
    check("rmem_req_up", mem_req, 1);
    repeat (2) @(negedge clk);
    check("rmem_req_held", mem_req, 1);
    reset = 1; cpu_req = 0;
    @(negedge clk);
    check("rmem_req_dropped", mem_req, 0);
    check("rmem_addr_clr", mem_addr, 0);
    check("rmem_rdata_clr", rdata, 0);
    reset = 0;
    #1;
    b_ppu = n_ppu; b_cpu = n_cpu; b_ldr = n_ldr;
    manual_req++;
    repeat (4) @(negedge clk); #1;
    check("rmem_no_ack", (n_ppu - b_ppu) + (n_cpu - b_cpu) + (n_ldr - b_ldr), 0);
    check("rmem_mem_req_low", mem_req, 0);
    @(negedge clk);
    mem_auto = 1; mem_lat = 1;
    cpu_req = 1; cpu_we = 0; cpu_allow = 1; cpu_addr = 22'h00_0ABC;
    wait_ack(1, 10, cyc);
    check("rmem_next_lat", cyc, 2);
    check("rmem_next_rdata", rdata, 8'h19);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
